// File: rtl/pvz_sprite_pkg.sv
// Shared types and constants for the PvZ sprite pipeline.
// Holds VGA timing, palette types and the peashooter sprite art pattern.
package pvz_sprite_pkg;

    localparam int H_TOTAL   = 800;
    localparam int V_TOTAL   = 525;
    localparam int H_VISIBLE = 640;
    localparam int V_VISIBLE = 480;

    typedef logic [3:0] pal_idx_t;
    typedef logic [9:0] screen_coord_t;

    localparam pal_idx_t TRANSPARENT_IDX_DEF = 4'd1;

    typedef enum logic {
        ST_IDLE,
        ST_ANIM
    } anim_state_t;

    // Sprite art as a closed-form pattern over the 15-bit word address:
    // low column bits, low row bits and the frame number are mixed so
    // that every address field leaves a visible trace in the index.
    function automatic pal_idx_t sprite_word(input logic [14:0] a);
        pal_idx_t w;
        w = a[3:0] ^ {a[7:6], 2'b00} ^ {1'b0, a[14:12]};
        return w;
    endfunction

endpackage

// File: rtl/peashooter_sprite_fetch_rom.sv
// Peashooter sprite ROM: single port, one-cycle synchronous read.
// Contents come from the sprite_word pattern in pvz_sprite_pkg.
module peashooter_rom
    import pvz_sprite_pkg::*;
#(
    parameter int AW = 15
) (
    input  logic          Clk,
    input  logic [AW-1:0] addr,
    output pal_idx_t      data
);

    // Registered read; data is valid one cycle after addr.
    always_ff @(posedge Clk) begin
        data <= sprite_word(15'(addr));
    end

endmodule

// File: rtl/peashooter_sprite_fetch.sv
// Peashooter sprite fetch: scan position -> ROM address -> palette index.
// Optional macro PEASHOOTER_HFLIP_EN adds an hflip input that mirrors columns.
module peashooter_sprite_fetch
    import pvz_sprite_pkg::*;
#(
    parameter int       SPRITE_W        = 64,
    parameter int       SPRITE_H        = 64,
    parameter int       NUM_FRAMES      = 8,
    parameter int       FRAME_HOLD      = 6,
    parameter pal_idx_t TRANSPARENT_IDX = TRANSPARENT_IDX_DEF,
    localparam int      FW = $clog2(NUM_FRAMES)
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          vs,
    input  logic          enable,
    input  logic [9:0]    draw_x,
    input  logic [9:0]    draw_y,
    input  logic [9:0]    pos_x,
    input  logic [9:0]    pos_y,
`ifdef PEASHOOTER_HFLIP_EN
    input  logic          hflip,
`endif
    output logic [3:0]    pal_index,
    output logic          sprite_on,
    output logic [FW-1:0] frame_num
);

    localparam int AW = $clog2(SPRITE_W * SPRITE_H * NUM_FRAMES);
    localparam int CW = $clog2(SPRITE_W);
    localparam int RW = $clog2(SPRITE_H);
    localparam int HW = $clog2(FRAME_HOLD);

    anim_state_t   state_q;
    anim_state_t   state_n;
    logic [HW-1:0] hold_q;
    logic [HW-1:0] hold_n;
    logic [FW-1:0] frame_q;
    logic [FW-1:0] frame_n;
    logic          vs_d;
    logic          vs_edge;

    logic [10:0]   x11;
    logic [10:0]   y11;
    logic [10:0]   px11;
    logic [10:0]   py11;
    logic          in_box_c;
    logic          in_box_q;
    logic [CW-1:0] col_off;
    logic [CW-1:0] col_c;
    logic [RW-1:0] row_off;
    logic [AW-1:0] addr_c;
    pal_idx_t      rom_data;

    assign vs_edge = vs & ~vs_d;

    // Animation state, hold counter, frame counter and vsync history.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
            frame_q <= '0;
            vs_d    <= 1'b0;
        end else begin
            state_q <= state_n;
            hold_q  <= hold_n;
            frame_q <= frame_n;
            vs_d    <= vs;
        end
    end

    // Next animation state; a dropped enable beats a coincident vs edge.
    always_comb begin
        state_n = state_q;
        hold_n  = hold_q;
        frame_n = frame_q;
        unique case (state_q)
            ST_IDLE: begin
                hold_n  = '0;
                frame_n = '0;
                if (enable) begin
                    state_n = ST_ANIM;
                end
            end
            ST_ANIM: begin
                if (!enable) begin
                    state_n = ST_IDLE;
                    hold_n  = '0;
                    frame_n = '0;
                end else if (vs_edge) begin
                    if (hold_q == HW'(FRAME_HOLD - 1)) begin
                        hold_n = '0;
                        if (frame_q == FW'(NUM_FRAMES - 1)) begin
                            frame_n = '0;
                        end else begin
                            frame_n = frame_q + 1'b1;
                        end
                    end else begin
                        hold_n = hold_q + 1'b1;
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Frame number is visible for debug.
    always_comb begin
        frame_num = frame_q;
    end

    // Stage 1 box test and address; 11-bit compares so pos+size never wraps.
    always_comb begin
        x11      = {1'b0, draw_x};
        y11      = {1'b0, draw_y};
        px11     = {1'b0, pos_x};
        py11     = {1'b0, pos_y};
        in_box_c = enable
                && (x11 >= px11) && (x11 < px11 + 11'(SPRITE_W))
                && (y11 >= py11) && (y11 < py11 + 11'(SPRITE_H));
        col_off  = CW'(draw_x - pos_x);
        row_off  = RW'(draw_y - pos_y);
`ifdef PEASHOOTER_HFLIP_EN
        col_c    = hflip ? (CW'(SPRITE_W - 1) - col_off) : col_off;
`else
        col_c    = col_off;
`endif
        addr_c   = '0;
        if (in_box_c) begin
            addr_c = AW'(frame_q) * AW'(SPRITE_W * SPRITE_H)
                   + AW'(row_off) * AW'(SPRITE_W)
                   + AW'(col_c);
        end
    end

    peashooter_rom #(
        .AW (AW)
    ) u_rom (
        .Clk  (Clk),
        .addr (addr_c),
        .data (rom_data)
    );

    // Stage 1 box flag and stage 2 output registers; ROM read sits between.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            in_box_q  <= 1'b0;
            pal_index <= '0;
            sprite_on <= 1'b0;
        end else begin
            in_box_q  <= in_box_c;
            pal_index <= rom_data;
            sprite_on <= in_box_q && (rom_data != TRANSPARENT_IDX);
        end
    end

endmodule

// File: tb/tb_peashooter_sprite_fetch.sv
// Directed bench for peashooter_sprite_fetch.
// Expected indices are hand-derived from the sprite art pattern.
module tb_peashooter_sprite_fetch;

    logic       Clk;
    logic       Reset;
    logic       vs;
    logic       enable;
    logic [9:0] draw_x;
    logic [9:0] draw_y;
    logic [9:0] pos_x;
    logic [9:0] pos_y;
`ifdef PEASHOOTER_HFLIP_EN
    logic       hflip;
`endif
    logic [3:0] pal_index;
    logic       sprite_on;
    logic [2:0] frame_num;

    int n_assert = 0;
    int n_fail   = 0;

    peashooter_sprite_fetch dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .vs        (vs),
        .enable    (enable),
        .draw_x    (draw_x),
        .draw_y    (draw_y),
        .pos_x     (pos_x),
        .pos_y     (pos_y),
`ifdef PEASHOOTER_HFLIP_EN
        .hflip     (hflip),
`endif
        .pal_index (pal_index),
        .sprite_on (sprite_on),
        .frame_num (frame_num)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pix(input string tag, input int x, input int y,
                       input int exp_pal, input int exp_on);
        draw_x = 10'(x);
        draw_y = 10'(y);
        tick();
        tick();
        chk({tag, "_pal"}, 32'(pal_index), 32'(exp_pal));
        chk({tag, "_on"}, 32'(sprite_on), 32'(exp_on));
    endtask

    task automatic vs_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            vs = 1'b1;
            tick();
            vs = 1'b0;
            tick();
        end
    endtask

    initial begin
        Reset  = 1'b1;
        vs     = 1'b0;
        enable = 1'b0;
        draw_x = '0;
        draw_y = '0;
        pos_x  = '0;
        pos_y  = '0;
`ifdef PEASHOOTER_HFLIP_EN
        hflip  = 1'b0;
`endif
        tick();
        tick();
        chk("rst_pal", 32'(pal_index), 32'd0);
        chk("rst_on", 32'(sprite_on), 32'd0);
        chk("rst_frame", 32'(frame_num), 32'd0);

        Reset  = 1'b0;
        enable = 1'b1;
        pos_x  = 10'd100;
        pos_y  = 10'd200;
        tick();

        // Top-left corner: addr 0 -> index 0, opaque.
        pix("tl", 100, 200, 0, 1);
        chk("tl_frame", 32'(frame_num), 32'd0);

        // Back-to-back pixels: addr 4095 -> 3, then just right of the box.
        draw_x = 10'd163;
        draw_y = 10'd263;
        tick();
        draw_x = 10'd164;
        draw_y = 10'd200;
        tick();
        chk("br_pal", 32'(pal_index), 32'd3);
        chk("br_on", 32'(sprite_on), 32'd1);
        tick();
        chk("right_on", 32'(sprite_on), 32'd0);
        chk("right_pal", 32'(pal_index), 32'd0);

        // Addr 1 holds the transparent key.
        pix("transp", 101, 200, 1, 0);
        // Row terms: addr 64 -> 4, addr 66 -> 6.
        pix("row1", 100, 201, 4, 1);
        pix("row1c2", 102, 201, 6, 1);
        // Outside the box on the left and below.
        pix("left", 99, 200, 0, 0);
        pix("below", 100, 264, 0, 0);

        // Animation stepping.
        vs_pulses(5);
        chk("hold5_frame", 32'(frame_num), 32'd0);
        vs_pulses(1);
        chk("hold6_frame", 32'(frame_num), 32'd1);
        pos_x = 10'd0;
        pos_y = 10'd0;
        pix("f1_origin", 0, 0, 1, 0);
        vs_pulses(42);
        chk("wrap_frame", 32'(frame_num), 32'd0);
        vs_pulses(18);
        chk("f3_frame", 32'(frame_num), 32'd3);
        pix("f3_origin", 0, 0, 3, 1);

        // Enable falls on the same cycle as a vs rising edge.
        vs     = 1'b1;
        enable = 1'b0;
        tick();
        vs     = 1'b0;
        chk("drop_frame", 32'(frame_num), 32'd0);
        pix("drop_pix", 0, 0, 0, 0);
        vs_pulses(6);
        chk("idle_frame", 32'(frame_num), 32'd0);

        // Reset mid-scan while inside the box.
        enable = 1'b1;
        pos_x  = 10'd100;
        pos_y  = 10'd200;
        pix("pre_rst", 100, 201, 4, 1);
        Reset = 1'b1;
        tick();
        chk("mid_rst_pal", 32'(pal_index), 32'd0);
        chk("mid_rst_on", 32'(sprite_on), 32'd0);
        Reset = 1'b0;
        tick();
        chk("post_rst1_on", 32'(sprite_on), 32'd0);
        tick();
        chk("post_rst2_on", 32'(sprite_on), 32'd1);
        chk("post_rst2_pal", 32'(pal_index), 32'd4);

`ifdef PEASHOOTER_HFLIP_EN
        // Mirrored: column 0 reads addr 63 -> index 15.
        hflip = 1'b1;
        pix("hflip", 100, 200, 15, 1);
        hflip = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/peashooter_sprite_fetch.md
Name: peashooter_sprite_fetch

Overview:
- Upstream stage of the peashooter colour palette.
- Converts the VGA scan position and the plant's screen position into a sprite ROM address.
- Reads the 4-bit palette index through a 2-stage pipeline and produces a per-pixel "sprite_on" flag, with transparency resolved.
- Steps the idle animation frame once per FRAME_HOLD vertical syncs; the top-level colour mux feeds pal_index to the palette.

Parameters:
- SPRITE_W, 64, sprite width in pixels.
- SPRITE_H, 64, sprite height in pixels.
- NUM_FRAMES, 8, animation frames, stacked vertically in the ROM (frame 0 at address 0).
- FRAME_HOLD, 6, vsync rising edges per animation frame.
- TRANSPARENT_IDX, 1, palette index treated as transparent (magenta key colour).

Ports:
- Clk  in  1  pixel clock.
- Reset  in  1  synchronous, active-high reset.
- vs  in  1  VGA vertical sync, level; the block detects its rising edge internally.
- enable  in  1  plant present in this cell; low blanks output and rewinds animation.
- draw_x  in  10  current scan column, 0..799.
- draw_y  in  10  current scan row, 0..524.
- pos_x  in  10  sprite top-left column.
- pos_y  in  10  sprite top-left row.
- pal_index  out  4  palette index for the pixel presented 2 cycles earlier.
- sprite_on  out  1  high when that pixel is inside the sprite box, enable was high, and the index is not TRANSPARENT_IDX.
- frame_num  out  $clog2(NUM_FRAMES)  current animation frame (debug/visibility).

Behaviour:
- Reset (synchronous): pal_index=0, sprite_on=0, frame_num=0, hold counter=0, vs edge register=0, stage-1 in_box/valid cleared. Reset asserted mid-frame clears the pipeline immediately; outputs are 0 on the cycle after Reset is sampled high.
- Stage 1 (registered): compute in_box = enable && draw_x>=pos_x && draw_x<pos_x+SPRITE_W && draw_y>=pos_y && draw_y<pos_y+SPRITE_H.
  - Compare at 11 bits; pos+size never wraps. A sprite partly off-screen is clipped naturally.
  - col = draw_x-pos_x, row = draw_y-pos_y.
  - addr = frame_num*SPRITE_W*SPRITE_H + row*SPRITE_W + col, width $clog2(SPRITE_W*SPRITE_H*NUM_FRAMES). When not in_box, addr is don't-care and is forced to 0.
- Stage 2: synchronous ROM read of addr. Register pal_index = rom_data, sprite_on = in_box_d && rom_data!=TRANSPARENT_IDX.
- Latency: exactly 2 Clk from (draw_x, draw_y) to the matching pal_index/sprite_on. Throughput is one pixel per clock, with no stalls.
- Animation FSM, states IDLE and ANIM:
  - IDLE: enable=0. frame_num=0, hold=0. Go to ANIM when enable=1.
  - ANIM: on each vs rising edge (vs=1 and vs_d=0), hold increments. When hold reaches FRAME_HOLD-1 and an edge occurs, hold resets to 0 and frame_num increments, wrapping from NUM_FRAMES-1 to 0.
  - ANIM: enable=0 returns to IDLE the next cycle, with frame_num=0.
- frame_num changes only on vs edges, so a frame never tears within a visible field.
- Simultaneous enable fall and vs edge: enable wins, giving frame_num=0.
- Edges of the draw_x/draw_y range (blanking region) behave per the in_box rule; no special casing.

Optional Feature:
- Macro PEASHOOTER_HFLIP_EN.
- Defined: adds input port hflip (1 bit). When hflip=1 in stage 1, col = SPRITE_W-1-(draw_x-pos_x). This mirrors the sprite horizontally without changing latency; hflip is sampled alongside draw_x.
- Undefined: port absent, col is never mirrored.

Decomposition:
- Shared package pvz_sprite_pkg holds:
  - VGA constants H_TOTAL=800, V_TOTAL=525, H_VISIBLE=640, V_VISIBLE=480.
  - TRANSPARENT_IDX default.
  - typedef pal_idx_t (logic [3:0]).
  - typedef screen_coord_t (logic [9:0]).
- One natural sub-module: peashooter_rom, a synchronous single-port read-only memory (address in, 4-bit data out, 1-cycle read, initialised from the sprite memory file). Only the FSM and address pipeline live in peashooter_sprite_fetch.

Test Plan:
- Reset then enable=1, pos=(100,200), draw=(100,200) at cycle t -> at t+2, sprite_on=1 and pal_index=ROM[0] (if that entry is not 1); frame_num=0.
- draw=(163,263) then draw=(164,200) with same pos -> first gives addr 4095 and sprite_on per data; second gives sprite_on=0 two cycles later.
- ROM word equal to 1 inside the box -> sprite_on=0, pal_index=1 (transparency).
- Apply 6 vs pulses with enable=1 -> frame_num goes 0→1; 48 pulses -> wraps to 0; pixel (0,0) then reads addr 4096*frame_num.
- enable drops mid-animation (frame_num=3) coinciding with a vs edge -> frame_num=0 next cycle, sprite_on=0 for all subsequent pixels.
- Reset pulsed for 1 cycle during an active in-box scan -> outputs 0 the following cycle; valid output resumes 2 cycles after Reset deasserts. With PEASHOOTER_HFLIP_EN and hflip=1, draw=(100,200) reads addr 63.
